apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

APB master that shares the two-slave peripheral bus (WDT on psel_0, memory on psel_1) between two requesters: requester 0 is the processor and requester 1 is the DMA/test port. It arbitrates requests round-robin, decodes the address to a slave select, and sequences the APB SETUP/ACCESS phases. It returns one response per accepted request and drives the master side of sys_if.

## Interface
- SEL_BIT, 12: paddr bit that selects the slave (0 selects psel_0/WDT, 1 selects psel_1/memory).
- TIMEOUT_CYCLES, 16: ACCESS-phase cycle limit. Used only with APB_TIMEOUT_EN.

Ports:
- pclk  in  1  APB clock; all logic is rising-edge.
- presetn  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; one-hot or zero; combinational from state and req_valid.
- req_write  in  2  per-requester write (1) or read (0).
- req_addr  in  2×address_t  per-requester address.
- req_wdata  in  2×data_t  per-requester write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  1  index of the requester that owns the response.
- rsp_rdata  out  data_t  read data; 0 for writes.
- rsp_err  out  1  timeout error; constant 0 without APB_TIMEOUT_EN.
- psel_0, psel_1, penable, pwrite  out  1  APB master controls.
- paddr  out  address_t; pwdata  out  data_t.
- pready_0, pready_1  in  1; prdata_0, prdata_1  in  data_t  APB slave returns.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE, any req_valid set:
  - Grant one requester. If both are valid, grant the one not served last. The pointer resets to favour requester 0.
  - Assert req_ready for the granted requester in that cycle.
  - Latch write/addr/wdata/id; go to SETUP.
- SETUP: assert psel_x for decoded slave x = paddr[SEL_BIT]; penable=0; go to ACCESS.
- ACCESS: psel_x=1, penable=1; sample pready_x of the selected slave only.
  - On pready_x=1: capture prdata_x (reads) and go to IDLE. Next cycle: rsp_valid=1 with rsp_id, rsp_rdata, rsp_err=0.
- paddr, pwrite, pwdata stay stable from SETUP through the last ACCESS cycle. In IDLE they hold their last values and psel_*/penable are 0.
- A requester holds req_valid and its fields stable until req_ready. A requester may not withdraw a request.
- The pready of the non-selected slave is ignored, as are prdata values outside the completing cycle.
- Reset (asynchronous, any state): FSM to IDLE; the in-flight transfer is abandoned with no response.
  - Reset values: psel_0=psel_1=penable=pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, rsp_err=0, RR pointer favouring requester 0; req_ready=0 while presetn=0.

## Timing
- Cycle 0: IDLE accepts the request. Cycle 1: SETUP. Cycle 2: first ACCESS cycle.
- With zero wait states, rsp_valid is in cycle 3, and a new request can be accepted in that same cycle. Minimum accept-to-accept interval is 3 cycles.
- Each slave wait cycle (pready low) adds one cycle.
- rsp_valid is registered and lasts exactly one cycle. There is no response backpressure.

## Configuration
- APB_TIMEOUT_EN defined:
  - A counter of ACCESS cycles resets in SETUP.
  - If TIMEOUT_CYCLES consecutive ACCESS cycles pass with pready_x low, drop psel_x/penable and go to IDLE.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - A pready arriving in the limit cycle wins, giving a normal response.
- APB_TIMEOUT_EN undefined: ACCESS waits indefinitely, there is no counter, and rsp_err is tied to 0.

## Structure
- typedef_pkg holds:
  - address_t (logic [31:0]) and data_t (logic [31:0]), both already used by sys_if;
  - the FSM enum apb_state_e {IDLE, SETUP, ACCESS};
  - the requester count constant N_REQ=2.
- Sub-module rr_arbiter (2-way round-robin, grant and pointer update on accept) is instantiated once.
- The APB side connects to sys_if master signals; this block does not drive wait_time.

## Test plan
- Write: requester 0 writes 0xDEADBEEF to 0x0000_0004, slave 0 has zero waits.
  - Required: psel_0 in cycles 1–2, penable in cycle 2 only; rsp_valid in cycle 3 with rsp_id=0, rsp_err=0.
- Read with waits: requester 1 reads 0x0000_1010, slave 1 holds pready low 3 cycles then returns 0x1234_5678.
  - Required: psel_1 is used; rsp_rdata=0x1234_5678 arrives 6 cycles after accept.
- Contention: both requesters are valid continuously for 4 transfers.
  - Required: grants alternate 0,1,0,1; every rsp_id matches its grant.
- Reset mid-ACCESS: presetn pulses low.
  - Required: all outputs go to reset values immediately, no rsp_valid follows, and the next request is granted to requester 0.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=16): slave 0 never asserts pready.
  - Required: after 16 ACCESS cycles psel_0 drops, followed by rsp_valid with rsp_err=1, rsp_rdata=0.
  - Same stimulus without the macro: the bus stays in ACCESS.

Source files
------------

// File: rtl/typedef_pkg.sv
// Shared types for the APB master/arbiter slice: bus word types, FSM encoding
// and the requester count.
package typedef_pkg;

    typedef logic [31:0] address_t;
    typedef logic [31:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int N_REQ = 2;

endpackage

// File: rtl/sys_if.sv
// Two-slave APB peripheral bus (WDT on psel_0, memory on psel_1).
// wait_time is slave-side configuration and is never driven by the master.
interface sys_if;
    import typedef_pkg::*;

    logic     psel_0;
    logic     psel_1;
    logic     penable;
    logic     pwrite;
    address_t paddr;
    data_t    pwdata;
    logic     pready_0;
    logic     pready_1;
    data_t    prdata_0;
    data_t    prdata_1;
    logic [7:0] wait_time;

    modport master (
        output psel_0, psel_1, penable, pwrite, paddr, pwdata,
        input  pready_0, pready_1, prdata_0, prdata_1
    );

    modport slave (
        input  psel_0, psel_1, penable, pwrite, paddr, pwdata, wait_time,
        output pready_0, pready_1, prdata_0, prdata_1
    );

endinterface

// File: rtl/rr_arbiter.sv
// Two-way round-robin arbiter. Grant is combinational; the "last served"
// pointer moves only when a grant is actually issued.
module rr_arbiter
    import typedef_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic             grant_id
);

    logic last_reg;

    // Reset value 1 means "requester 1 was served last", so 0 wins first.
    always_comb begin
        grant_id = 1'b0;
        if (req[0] && req[1]) begin
            grant_id = ~last_reg;
        end else begin
            grant_id = req[1];
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
        assign grant[gi] = enable && req[gi] && (grant_id == 1'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else if (|grant) begin
            last_reg <= grant_id;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters with round-robin arbitration.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter
    import typedef_pkg::*;
#(
    parameter int SEL_BIT        = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    input  logic [N_REQ-1:0] req_write,
    input  address_t         req_addr  [N_REQ],
    input  data_t            req_wdata [N_REQ],
    output logic             rsp_valid,
    output logic             rsp_id,
    output data_t            rsp_rdata,
    output logic             rsp_err,
    sys_if.master            apb
);

    apb_state_e state_reg, state_next;

    address_t addr_reg;
    data_t    wdata_reg;
    logic     write_reg;
    logic     id_reg;

    logic     rsp_valid_reg;
    logic     rsp_id_reg;
    data_t    rsp_rdata_reg;

    logic [N_REQ-1:0] grant;
    logic             grant_id;
    logic             accept;
    logic             arb_enable;

    logic  sel_slave;
    logic  pready_sel;
    data_t prdata_sel;
    logic  done;
    logic  timeout;
    logic  psel_0_c, psel_1_c, penable_c;

    // Gate with presetn so nothing is accepted while reset is held.
    assign arb_enable = (state_reg == IDLE) && presetn;
    assign accept     = |grant;
    assign req_ready  = grant;

    rr_arbiter u_arb (
        .clk      (pclk),
        .rst_n    (presetn),
        .req      (req_valid),
        .enable   (arb_enable),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign sel_slave  = addr_reg[SEL_BIT];
    assign pready_sel = sel_slave ? apb.pready_1 : apb.pready_0;
    assign prdata_sel = sel_slave ? apb.prdata_1 : apb.prdata_0;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             limit_hit;
    logic             rsp_err_reg;

    assign limit_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_reg     <= '0;
            rsp_err_reg <= 1'b0;
        end else begin
            if (state_reg == SETUP) begin
                cnt_reg <= '0;
            end else if (state_reg == ACCESS) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (done || timeout) begin
                rsp_err_reg <= timeout;
            end
        end
    end

    assign rsp_err = rsp_err_reg;
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        done       = 1'b0;
        timeout    = 1'b0;
        psel_0_c   = 1'b0;
        psel_1_c   = 1'b0;
        penable_c  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                psel_0_c   = !sel_slave;
                psel_1_c   = sel_slave;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel_0_c  = !sel_slave;
                psel_1_c  = sel_slave;
                penable_c = 1'b1;
                // A pready in the limit cycle takes priority over the timeout.
                if (pready_sel) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (limit_hit) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            write_reg     <= 1'b0;
            id_reg        <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg  <= req_addr[grant_id];
                wdata_reg <= req_wdata[grant_id];
                write_reg <= req_write[grant_id];
                id_reg    <= grant_id;
            end
            rsp_valid_reg <= done || timeout;
            if (done || timeout) begin
                rsp_id_reg    <= id_reg;
                rsp_rdata_reg <= (done && !write_reg) ? prdata_sel : '0;
            end
        end
    end

    assign apb.psel_0  = psel_0_c;
    assign apb.psel_1  = psel_1_c;
    assign apb.penable = penable_c;
    assign apb.pwrite  = write_reg;
    assign apb.paddr   = addr_reg;
    assign apb.pwdata  = wdata_reg;

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter; inputs change on the falling edge and
// outputs are sampled 1 ns later. Timeout scenario depends on APB_TIMEOUT_EN.
module tb_apb_master_arbiter;
    import typedef_pkg::*;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic [1:0] req_valid, req_ready, req_write;
    address_t   req_addr  [2];
    data_t      req_wdata [2];
    logic       rsp_valid, rsp_id, rsp_err;
    data_t      rsp_rdata;

    int checks = 0;
    int errors = 0;

    sys_if bus ();

    apb_master_arbiter #(.SEL_BIT(12), .TIMEOUT_CYCLES(16)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (bus.master)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (rsp_valid === 1'b1)
            $display("txn: t=%0t id=%0d rdata=%h err=%b", $time, rsp_id, rsp_rdata, rsp_err);
    end

    task automatic test_reset();
        req_valid = 2'b11; req_write = 2'b11;
        req_addr[0] = 32'h0; req_addr[1] = 32'h0;
        req_wdata[0] = 32'h0; req_wdata[1] = 32'h0;
        bus.pready_0 = 1'b0; bus.pready_1 = 1'b0;
        bus.prdata_0 = 32'h0; bus.prdata_1 = 32'h0; bus.wait_time = 8'd0;
        presetn = 1'b0;
        @(negedge pclk); #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if ({bus.psel_0, bus.psel_1, bus.penable, bus.pwrite} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.psel_0, bus.psel_1, bus.penable, bus.pwrite}); end
        checks++; if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0) begin errors++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", bus.paddr, bus.pwdata); end
        checks++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b000 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp: got %b%b%b/%h expected 000/0", rsp_valid, rsp_id, rsp_err, rsp_rdata); end
        @(negedge pclk);
        req_valid = 2'b00;
        presetn = 1'b1;
        @(negedge pclk);
    endtask

    task automatic test_write();
        req_valid = 2'b01; req_write = 2'b01;
        req_addr[0] = 32'h0000_0004; req_wdata[0] = 32'hDEAD_BEEF;
        bus.pready_0 = 1'b1; bus.pready_1 = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_accept: got %b expected 01", req_ready); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge pclk);
            req_valid = 2'b00;
            #1;
            checks++; if (bus.psel_0 !== (c == 1 || c == 2)) begin errors++; $display("FAIL wr_psel_0 c%0d: got %b expected %b", c, bus.psel_0, (c == 1 || c == 2)); end
            checks++; if (bus.penable !== (c == 2)) begin errors++; $display("FAIL wr_penable c%0d: got %b expected %b", c, bus.penable, (c == 2)); end
            checks++; if (rsp_valid !== (c == 3)) begin errors++; $display("FAIL wr_rsp_valid c%0d: got %b expected %b", c, rsp_valid, (c == 3)); end
            if (c <= 2) begin
                checks++; if (bus.paddr !== 32'h4 || bus.pwrite !== 1'b1 || bus.pwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_bus c%0d: got %h/%b/%h expected 4/1/deadbeef", c, bus.paddr, bus.pwrite, bus.pwdata); end
            end
            if (c == 3) begin
                checks++; if (rsp_id !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp_fields: got id=%b err=%b expected 0/0", rsp_id, rsp_err); end
            end
        end
    endtask

    task automatic test_read_wait();
        @(negedge pclk);
        req_valid = 2'b10; req_write = 2'b00;
        req_addr[1] = 32'h0000_1010; req_wdata[1] = 32'h0;
        bus.pready_0 = 1'b1; bus.pready_1 = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rd_accept: got %b expected 10", req_ready); end
        for (int c = 1; c <= 7; c++) begin
            @(negedge pclk);
            req_valid = 2'b00;
            bus.pready_1 = (c == 5);
            bus.prdata_1 = (c == 5) ? 32'h1234_5678 : (32'hBAD0_0000 | 32'(c));
            #1;
            checks++; if (bus.psel_1 !== (c <= 5) || bus.psel_0 !== 1'b0) begin errors++; $display("FAIL rd_psel c%0d: got %b%b expected %b0", c, bus.psel_1, bus.psel_0, (c <= 5)); end
            checks++; if (bus.penable !== (c >= 2 && c <= 5)) begin errors++; $display("FAIL rd_penable c%0d: got %b expected %b", c, bus.penable, (c >= 2 && c <= 5)); end
            checks++; if (rsp_valid !== (c == 6)) begin errors++; $display("FAIL rd_rsp_valid c%0d: got %b expected %b", c, rsp_valid, (c == 6)); end
            if (c == 6) begin
                checks++; if (rsp_rdata !== 32'h1234_5678 || rsp_id !== 1'b1) begin errors++; $display("FAIL rd_rsp_data: got %h id=%b expected 12345678 id=1", rsp_rdata, rsp_id); end
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_ready;
        logic       exp_rsp;
        logic       exp_id;
        int         t;
        req_write = 2'b00;
        req_addr[0] = 32'h0000_0020; req_addr[1] = 32'h0000_1020;
        bus.pready_0 = 1'b1; bus.pready_1 = 1'b1;
        bus.prdata_0 = 32'hA0A0_A0A0; bus.prdata_1 = 32'hB1B1_B1B1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge pclk);
            req_valid = (c <= 9) ? 2'b11 : 2'b00;
            #1;
            t = c / 3;
            exp_ready = (c % 3 == 0 && c <= 9) ? ((t % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_rsp = (c % 3 == 0 && c >= 3);
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_grant c%0d: got %b expected %b", c, req_ready, exp_ready); end
            checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL rr_rsp_valid c%0d: got %b expected %b", c, rsp_valid, exp_rsp); end
            if (exp_rsp) begin
                exp_id = ((t - 1) % 2 == 1);
                checks++; if (rsp_id !== exp_id || rsp_rdata !== (exp_id ? 32'hB1B1_B1B1 : 32'hA0A0_A0A0)) begin errors++; $display("FAIL rr_rsp c%0d: got id=%b %h expected id=%b", c, rsp_id, rsp_rdata, exp_id); end
            end
            if (c % 3 != 0) begin
                checks++; if (bus.psel_0 !== (t % 2 == 0) || bus.psel_1 !== (t % 2 == 1)) begin errors++; $display("FAIL rr_psel c%0d: got %b%b expected %b%b", c, bus.psel_1, bus.psel_0, (t % 2 == 1), (t % 2 == 0)); end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge pclk);
        req_valid = 2'b01; req_write = 2'b01;
        req_addr[0] = 32'h0000_0008; req_wdata[0] = 32'hCAFE_F00D;
        bus.pready_0 = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_accept: got %b expected 01", req_ready); end
        @(negedge pclk); req_valid = 2'b00;
        @(negedge pclk);
        @(negedge pclk); #1;
        checks++; if (bus.penable !== 1'b1 || bus.pwrite !== 1'b1) begin errors++; $display("FAIL rst_in_access: got en=%b wr=%b expected 1/1", bus.penable, bus.pwrite); end
        #1;
        presetn = 1'b0;
        req_valid = 2'b11; req_write = 2'b00;
        #1;
        checks++; if ({bus.psel_0, bus.psel_1, bus.penable, bus.pwrite} !== 4'b0000) begin errors++; $display("FAIL rst_ctrl: got %b expected 0000", {bus.psel_0, bus.psel_1, bus.penable, bus.pwrite}); end
        checks++; if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0) begin errors++; $display("FAIL rst_addr_data: got %h/%h expected 0/0", bus.paddr, bus.pwdata); end
        checks++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b000 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp: got %b%b%b/%h expected 000/0", rsp_valid, rsp_id, rsp_err, rsp_rdata); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b expected 00", req_ready); end
        @(negedge pclk);
        presetn = 1'b1;
        bus.pready_0 = 1'b1; bus.prdata_0 = 32'h55AA_55AA;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_first_grant: got %b expected 01", req_ready); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge pclk);
            req_valid = 2'b00;
            #1;
            checks++; if (rsp_valid !== (c == 3)) begin errors++; $display("FAIL rst_rsp_valid c%0d: got %b expected %b", c, rsp_valid, (c == 3)); end
            if (c == 3) begin
                checks++; if (rsp_id !== 1'b0 || rsp_rdata !== 32'h55AA_55AA) begin errors++; $display("FAIL rst_rsp_data: got id=%b %h expected 0 55aa55aa", rsp_id, rsp_rdata); end
            end
        end
    endtask

    task automatic test_timeout();
        @(negedge pclk);
        req_valid = 2'b01; req_write = 2'b01;
        req_addr[0] = 32'h0000_0000; req_wdata[0] = 32'h0000_00FF;
        bus.pready_0 = 1'b0; bus.prdata_0 = 32'hEEEE_EEEE;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL to_accept: got %b expected 01", req_ready); end
`ifdef APB_TIMEOUT_EN
        for (int c = 1; c <= 19; c++) begin
            @(negedge pclk);
            req_valid = 2'b00;
            #1;
            checks++; if (bus.psel_0 !== (c <= 17) || bus.penable !== (c >= 2 && c <= 17)) begin errors++; $display("FAIL to_bus c%0d: got sel=%b en=%b expected %b/%b", c, bus.psel_0, bus.penable, (c <= 17), (c >= 2 && c <= 17)); end
            checks++; if (rsp_valid !== (c == 18)) begin errors++; $display("FAIL to_rsp_valid c%0d: got %b expected %b", c, rsp_valid, (c == 18)); end
            if (c == 18) begin
                checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_rsp_err: got err=%b %h expected 1 0", rsp_err, rsp_rdata); end
            end
        end
        // pready in the 16th ACCESS cycle must still complete normally.
        req_valid = 2'b01; req_write = 2'b00;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL lim_accept: got %b expected 01", req_ready); end
        for (int c = 1; c <= 18; c++) begin
            @(negedge pclk);
            req_valid = 2'b00;
            bus.pready_0 = (c == 17);
            bus.prdata_0 = (c == 17) ? 32'h0000_0077 : 32'hEEEE_EEEE;
            #1;
            checks++; if (rsp_valid !== (c == 18)) begin errors++; $display("FAIL lim_rsp_valid c%0d: got %b expected %b", c, rsp_valid, (c == 18)); end
            if (c == 18) begin
                checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0000_0077) begin errors++; $display("FAIL lim_rsp: got err=%b %h expected 0 77", rsp_err, rsp_rdata); end
            end
        end
`else
        for (int c = 1; c <= 40; c++) begin
            @(negedge pclk);
            req_valid = 2'b00;
            #1;
            checks++; if (bus.psel_0 !== 1'b1 || bus.penable !== (c >= 2) || rsp_valid !== 1'b0) begin errors++; $display("FAIL nto_hold c%0d: got sel=%b en=%b rsp=%b expected 1/%b/0", c, bus.psel_0, bus.penable, rsp_valid, (c >= 2)); end
        end
        presetn = 1'b0;
        #1;
        presetn = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_contention();
        test_reset_mid_access();
        test_timeout();
        @(negedge pclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
